// File: rtl/nps_rom_arb_pkg.sv
// Shared constants for the two-requester NPS_rom frame arbiter.
package nps_rom_arb_pkg;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;

  // Drain watchdog width; never zero even for the smallest legal TIMEOUT.
  function automatic int wd_width(input int timeout);
    return (timeout <= 2) ? 1 : $clog2(timeout);
  endfunction

endpackage

// File: rtl/nps_rom_arb_if.sv
// Requester and ROM-side signal bundle of nps_rom_arb.
interface nps_rom_arb_if #(
  parameter int DATA_WIDTH = 24,
  parameter int ADR_WIDTH  = 9
);
  logic                  req0, req1, gnt0, gnt1;
  logic                  vi0, vi1, fi0, fi1;
  logic [ADR_WIDTH-1:0]  datai0, datai1;
  logic                  vo0, vo1, fo0, fo1;
  logic [DATA_WIDTH-1:0] datao0, datao1;
  logic                  rom_start, rom_set, rom_vi, rom_fi;
  logic [ADR_WIDTH-1:0]  rom_datai;
  logic                  rom_vo, rom_fo;
  logic [DATA_WIDTH-1:0] rom_datao;
  logic                  busy, timeout_err;

  // Requesters plus the ROM, seen from outside the arbiter.
  modport master (
    output req0, req1, vi0, vi1, fi0, fi1, datai0, datai1, rom_vo, rom_fo, rom_datao,
    input  gnt0, gnt1, vo0, vo1, fo0, fo1, datao0, datao1,
           rom_start, rom_set, rom_vi, rom_fi, rom_datai, busy, timeout_err
  );

  modport slave (
    input  req0, req1, vi0, vi1, fi0, fi1, datai0, datai1, rom_vo, rom_fo, rom_datao,
    output gnt0, gnt1, vo0, vo1, fo0, fo1, datao0, datao1,
           rom_start, rom_set, rom_vi, rom_fi, rom_datai, busy, timeout_err
  );
endinterface

// File: rtl/nps_rom_arb_rr.sv
// Two-way round-robin pick; ptr favours the requester that did not own the last frame.
module nps_rr_arb2 (
  input  logic       clk,
  input  logic       reset_x,
  input  logic [1:0] req,
  input  logic       owner,
  input  logic       rel,
  output logic       pick
);
  logic ptr;

  always_comb pick = (req == 2'b11) ? ptr : req[1];

  always_ff @(posedge clk or negedge reset_x)
    if (!reset_x)  ptr <= 1'b0;
    else if (rel)  ptr <= ~owner;

endmodule

// File: rtl/nps_rom_arb.sv
// Frame-level arbiter sharing one NPS_rom between two stream requesters.
module nps_rom_arb
  import nps_rom_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 24,
  parameter int ADR_WIDTH  = 9,
  parameter int TIMEOUT    = 1024
) (
  input  logic         clk,
  input  logic         reset_x,
  nps_rom_arb_if.slave bus
);
  localparam int            WW      = wd_width(TIMEOUT);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);

  logic [1:0]                  state, gnt;
  logic                        sel, pick, active, wd_exp, rel;
  logic                        req_g, vi_g, fi_g;
  logic [ADR_WIDTH-1:0]        datai_g, rom_datai_q;
  logic [WW-1:0]               wd;
  logic                        rom_start_q, rom_vi_q, rom_fi_q, tmo_q;
  logic [1:0]                  vo_q, fo_q;
  logic [1:0][DATA_WIDTH-1:0]  datao_q;

  assign active  = (state != S_IDLE);
  assign wd_exp  = (state == S_DRAIN) && (wd == WD_LAST);
  assign rel     = active && (bus.rom_fo || wd_exp);
  assign req_g   = sel ? bus.req1   : bus.req0;
  assign vi_g    = sel ? bus.vi1    : bus.vi0;
  assign fi_g    = sel ? bus.fi1    : bus.fi0;
  assign datai_g = sel ? bus.datai1 : bus.datai0;

  nps_rr_arb2 u_rr (
    .clk     (clk),
    .reset_x (reset_x),
    .req     ({bus.req1, bus.req0}),
    .owner   (sel),
    .rel     (rel),
    .pick    (pick)
  );

  always_ff @(posedge clk or negedge reset_x)
    if (!reset_x) begin
      state       <= S_IDLE;
      sel         <= 1'b0;
      gnt         <= '0;
      wd          <= '0;
      rom_start_q <= 1'b0;
      rom_vi_q    <= 1'b0;
      rom_fi_q    <= 1'b0;
      rom_datai_q <= '0;
      tmo_q       <= 1'b0;
    end else begin
      rom_start_q <= 1'b0;
      rom_vi_q    <= 1'b0;
      rom_fi_q    <= 1'b0;
      tmo_q       <= 1'b0;
      case (state)
        S_IDLE:
          if (bus.req0 || bus.req1) begin
            sel         <= pick;
            gnt         <= pick ? 2'b10 : 2'b01;
            rom_start_q <= 1'b1;
            state       <= S_STREAM;
          end
        S_STREAM: begin
          // A dropped request closes the frame exactly like an end-of-frame beat.
          rom_vi_q <= vi_g && req_g;
          rom_fi_q <= fi_g || !req_g;
          if (vi_g && req_g) rom_datai_q <= datai_g;
          if (fi_g || !req_g) begin
            state <= S_DRAIN;
            wd    <= '0;
          end
        end
        S_DRAIN:  wd    <= wd + 1'b1;
        default:  state <= S_IDLE;
      endcase
      // rom_fo wins over a simultaneous watchdog expiry.
      if (rel) begin
        state <= S_IDLE;
        gnt   <= '0;
        tmo_q <= !bus.rom_fo;
      end
    end

  // Return path: gnt is high exactly while a lane owns the ROM, so it doubles as lane enable.
  always_ff @(posedge clk or negedge reset_x)
    if (!reset_x) begin
      vo_q    <= '0;
      fo_q    <= '0;
      datao_q <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (gnt[i]) begin
          vo_q[i] <= bus.rom_vo;
          fo_q[i] <= bus.rom_fo;
          if (bus.rom_vo) datao_q[i] <= bus.rom_datao;
        end else begin
          vo_q[i]    <= 1'b0;
          fo_q[i]    <= 1'b0;
          datao_q[i] <= '0;
        end
      end
    end

  assign bus.gnt0        = gnt[0];
  assign bus.gnt1        = gnt[1];
  assign bus.vo0         = vo_q[0];
  assign bus.vo1         = vo_q[1];
  assign bus.fo0         = fo_q[0];
  assign bus.fo1         = fo_q[1];
  assign bus.datao0      = datao_q[0];
  assign bus.datao1      = datao_q[1];
  assign bus.rom_start   = rom_start_q;
  assign bus.rom_set     = 1'b0;
  assign bus.rom_vi      = rom_vi_q;
  assign bus.rom_fi      = rom_fi_q;
  assign bus.rom_datai   = rom_datai_q;
  assign bus.busy        = active;
  assign bus.timeout_err = tmo_q;

endmodule

// File: tb/tb_nps_rom_arb.sv
// Frame table plus abort / reset-in-drain sequences, with forward and return scoreboards.
module tb_nps_rom_arb;
  localparam int DW = 24;
  localparam int AW = 9;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic reset_x = 1'b0;
  always #5 clk = ~clk;

  nps_rom_arb_if #(.DATA_WIDTH(DW), .ADR_WIDTH(AW)) bus ();

  nps_rom_arb #(.DATA_WIDTH(DW), .ADR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .clk     (clk),
    .reset_x (reset_x),
    .bus     (bus)
  );

  typedef struct {
    logic [1:0] req;
    int         len;
    int         base;
    bit         noisy;
    bit         fo_en;
    int         rel;
    int         exp_g;
  } vec_t;

  typedef struct {
    int          g;
    logic [DW-1:0] d;
  } ret_t;

  int total = 0;
  int bad   = 0;
  logic [AW-1:0] fwd_q[$];
  ret_t          ret_q[$];
  int vo_c[2], fo_c[2];
  int rs_c, te_c;
  int cur_g = 0;
  bit rom_fo_en = 1'b1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] rom_fn(input logic [AW-1:0] a);
    return {a[5:0] ^ 6'h2A, ~a, a};
  endfunction

  // ROM model: one-cycle latency, rom_fo aligned with the data of the fi beat.
  logic          p_vi = 1'b0, p_fi = 1'b0;
  logic [AW-1:0] p_ad = '0;
  always @(negedge clk) begin
    p_vi = bus.rom_vi;
    p_fi = bus.rom_fi;
    p_ad = bus.rom_datai;
  end
  always @(posedge clk) begin
    #1;
    bus.rom_vo    = reset_x & p_vi;
    bus.rom_fo    = reset_x & p_fi & rom_fo_en;
    bus.rom_datao = p_vi ? rom_fn(p_ad) : '0;
    if (bus.rom_vo) ret_q.push_back('{cur_g, rom_fn(p_ad)});
  end

  task automatic step();
    ret_t r;
    @(posedge clk);
    #2;
    chk("gnt_onehot", bus.gnt0 & bus.gnt1, 0);
    chk("rom_set", bus.rom_set, 0);
    if (bus.rom_vi) begin
      if (fwd_q.size() == 0) chk("fwd_extra_beat", bus.rom_vi, 0);
      else                   chk("fwd_addr", bus.rom_datai, fwd_q.pop_front());
    end
    if (bus.vo0 || bus.vo1) begin
      if (ret_q.size() == 0) chk("ret_extra_beat", {bus.vo1, bus.vo0}, 0);
      else begin
        r = ret_q.pop_front();
        chk("ret_owner", {bus.vo1, bus.vo0}, (r.g == 1) ? 2 : 1);
        chk("ret_data", (r.g == 1) ? bus.datao1 : bus.datao0, r.d);
      end
    end
    if (bus.vo0) vo_c[0]++;
    if (bus.vo1) vo_c[1]++;
    if (bus.fo0) fo_c[0]++;
    if (bus.fo1) fo_c[1]++;
    if (bus.rom_start) rs_c++;
    if (bus.timeout_err) te_c++;
  endtask

  task automatic drive(input int g, input logic vi, input logic fi, input logic [AW-1:0] a);
    if (g == 0) begin bus.vi0 = vi; bus.fi0 = fi; bus.datai0 = a; end
    else        begin bus.vi1 = vi; bus.fi1 = fi; bus.datai1 = a; end
  endtask

  task automatic clr_cnt();
    vo_c = '{0, 0};
    fo_c = '{0, 0};
    rs_c = 0;
    te_c = 0;
  endtask

  task automatic run_frame(input vec_t t);
    logic [AW-1:0] a;
    int n;
    int o;
    o = 1 - t.exp_g;
    clr_cnt();
    rom_fo_en = t.fo_en;
    cur_g     = t.exp_g;
    bus.req0  = t.req[0];
    bus.req1  = t.req[1];
    n = 0;
    do begin step(); n++; end while (!(bus.gnt0 || bus.gnt1) && n < 8);
    chk("grant_owner", {bus.gnt1, bus.gnt0}, (t.exp_g == 1) ? 2 : 1);
    chk("grant_lat", n, 1);
    chk("timeout_pulse_width", bus.timeout_err, 0);
    if (t.noisy) begin bus.vi1 = 1'b1; bus.fi1 = 1'b1; bus.datai1 = 9'h1FF; end
    for (int b = 0; b < t.len; b++) begin
      a = AW'((b + t.base) % 512);
      drive(t.exp_g, 1'b1, b == t.len - 1, a);
      fwd_q.push_back(a);
      step();
    end
    drive(t.exp_g, 1'b0, 1'b0, '0);
    if (t.noisy) begin bus.vi1 = 1'b0; bus.fi1 = 1'b0; bus.datai1 = '0; end
    n = 0;
    do begin step(); n++; end while ((bus.gnt0 || bus.gnt1) && n < 40);
    chk("release_lat", n, t.rel);
    chk("fo_at_release", (t.exp_g == 1) ? bus.fo1 : bus.fo0, t.fo_en);
    chk("timeout_at_release", bus.timeout_err, !t.fo_en);
    chk("idle_gap_busy", bus.busy, 0);
    chk("datao_other", (o == 1) ? bus.datao1 : bus.datao0, 0);
    chk("rom_start_cnt", rs_c, 1);
    chk("vo_cnt", vo_c[t.exp_g], t.len);
    chk("fo_cnt", fo_c[t.exp_g], t.fo_en);
    chk("other_quiet", vo_c[o] + fo_c[o], 0);
    chk("timeout_cnt", te_c, !t.fo_en);
    chk("fwd_drained", fwd_q.size(), 0);
  endtask

  vec_t vecs[6];
  int   n;

  initial begin
    //          req    len  base noisy fo_en rel exp_g
    vecs[0] = '{2'b11, 512, 0,   0,    1,    2,  0};
    vecs[1] = '{2'b11, 4,   100, 0,    1,    2,  1};
    vecs[2] = '{2'b11, 3,   200, 0,    1,    2,  0};
    vecs[3] = '{2'b01, 5,   300, 1,    1,    2,  0};
    vecs[4] = '{2'b10, 2,   400, 0,    0,    TO, 1};
    vecs[5] = '{2'b11, 2,   450, 0,    1,    2,  0};

    bus.req0 = 1'b0; bus.req1 = 1'b0;
    drive(0, 1'b0, 1'b0, '0);
    drive(1, 1'b0, 1'b0, '0);
    clr_cnt();
    step(); step();
    chk("rst_gnt", {bus.gnt1, bus.gnt0}, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_rom", {bus.rom_start, bus.rom_vi, bus.rom_fi, bus.timeout_err}, 0);
    chk("rst_ret", {bus.vo1, bus.vo0, bus.fo1, bus.fo0}, 0);
    chk("rst_datao", {bus.datao1, bus.datao0}, 0);
    reset_x = 1'b1;
    step();

    for (int v = 0; v < 6; v++) run_frame(vecs[v]);
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    step();

    // Requester 0 drops req after three beats.
    clr_cnt(); cur_g = 0; rom_fo_en = 1'b1;
    bus.req0 = 1'b1;
    step();
    chk("abort_grant", {bus.gnt1, bus.gnt0}, 1);
    for (int b = 0; b < 3; b++) begin
      drive(0, 1'b1, 1'b0, AW'(20 + b));
      fwd_q.push_back(AW'(20 + b));
      step();
    end
    drive(0, 1'b0, 1'b0, '0);
    bus.req0 = 1'b0;
    step();
    chk("abort_rom_fi", bus.rom_fi, 1);
    chk("abort_rom_vi", bus.rom_vi, 0);
    chk("abort_drain_gnt", bus.gnt0, 1);
    n = 0;
    do begin step(); n++; end while (bus.gnt0 && n < 40);
    chk("abort_release_lat", n, 2);
    chk("abort_fo0", bus.fo0, 1);
    chk("abort_vo_cnt", vo_c[0], 3);

    // Reset asserted while requester 1 is in DRAIN.
    cur_g = 1;
    bus.req1 = 1'b1;
    step();
    chk("rd_grant", {bus.gnt1, bus.gnt0}, 2);
    drive(1, 1'b1, 1'b0, 9'd7); fwd_q.push_back(9'd7); step();
    drive(1, 1'b1, 1'b1, 9'd8); fwd_q.push_back(9'd8); step();
    drive(1, 1'b0, 1'b0, '0);
    chk("rd_in_drain", bus.rom_fi, 1);
    reset_x = 1'b0;
    #1;
    chk("rd_async_gnt", {bus.gnt1, bus.gnt0}, 0);
    chk("rd_async_busy", bus.busy, 0);
    chk("rd_async_rom", {bus.rom_start, bus.rom_vi, bus.rom_fi, bus.timeout_err}, 0);
    chk("rd_async_ret", {bus.vo1, bus.vo0, bus.fo1, bus.fo0}, 0);
    chk("rd_async_datao", {bus.datao1, bus.datao0}, 0);
    ret_q.delete();
    fwd_q.delete();
    bus.req1 = 1'b0;
    clr_cnt();
    step(); step();
    chk("rd_no_fo", fo_c[0] + fo_c[1], 0);
    reset_x = 1'b1;
    step();
    // ptr was 1 before reset; a tie must now go to requester 0.
    run_frame('{2'b11, 3, 30, 0, 1, 2, 0});
    run_frame('{2'b10, 3, 60, 0, 1, 2, 1});
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    step();
    chk("ret_drained", ret_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
